rca_pipe: RTL and testbench



---
 rtl/rca_pipe.sv | 126 ++++++++++++
 tb/tb_rca_pipe.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rca_pipe.sv
// Pipelined ripple-carry adder/subtractor: one SEG_W-bit segment resolved per stage,
// with a single global advance enable shared by every stage and by the input handshake.
module rca_pipe #(
    parameter int WIDTH = 32,
    parameter int SEG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int STAGES = WIDTH / SEG_W;

    logic en_s;

    assign en_s     = !out_valid || out_ready;
    assign in_ready = en_s;

    for (genvar g = 0; g < STAGES; g++) begin : stg
        localparam int LO = g * SEG_W;
        localparam int HI = LO + SEG_W - 1;

        logic [WIDTH-1:LO] a_in_s;
        logic [WIDTH-1:LO] b_in_s;
        logic              c_in_s;
        logic              v_in_s;
        logic [SEG_W:0]    seg_s;
        logic [HI:0]       s_d;
        logic [HI:0]       s_q;
        logic              v_d;
        logic              v_q;
        logic              c_d;
        logic              c_q;

        assign seg_s = {1'b0, a_in_s[HI:LO]} + {1'b0, b_in_s[HI:LO]} + {{SEG_W{1'b0}}, c_in_s};

        // Bubbles carry all-zero payload so an idle pipe presents sum/cout/ovf = 0.
        if (g == 0) begin : src
            always_comb begin
                a_in_s = a;
                b_in_s = sub ? ~b : b;
                c_in_s = sub ? 1'b1 : cin;
                v_in_s = in_valid;
                if (v_in_s) begin
                    s_d = seg_s[SEG_W-1:0];
                end else begin
                    s_d = '0;
                end
            end
        end else begin : src
            always_comb begin
                a_in_s = stg[g-1].sk.a_q;
                b_in_s = stg[g-1].sk.b_q;
                c_in_s = stg[g-1].c_q;
                v_in_s = stg[g-1].v_q;
                if (v_in_s) begin
                    s_d = {seg_s[SEG_W-1:0], stg[g-1].s_q};
                end else begin
                    s_d = '0;
                end
            end
        end

        assign v_d = v_in_s;
        assign c_d = v_in_s & seg_s[SEG_W];

        // Stage valid, segment carry and accumulated low sum bits.
        always_ff @(posedge clk) begin
            if (rst) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (en_s) begin
                v_q <= v_d;
                c_q <= c_d;
                s_q <= s_d;
            end
        end

        if (g < STAGES - 1) begin : sk
            logic [WIDTH-1:HI+1] a_q;
            logic [WIDTH-1:HI+1] b_q;

            // Skew registers: operand segments not yet consumed by a later stage.
            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (en_s) begin
                    a_q <= v_in_s ? a_in_s[WIDTH-1:HI+1] : '0;
                    b_q <= v_in_s ? b_in_s[WIDTH-1:HI+1] : '0;
                end
            end
        end else begin : fin
            logic ovf_d;
            logic ovf_q;

            assign ovf_d = v_in_s && (a_in_s[WIDTH-1] == b_in_s[WIDTH-1])
                                  && (seg_s[SEG_W-1] != a_in_s[WIDTH-1]);

            // Signed overflow is judged in the last stage where the operand MSBs arrive.
            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (en_s) begin
                    ovf_q <= ovf_d;
                end
            end

            assign out_valid = v_q;
            assign sum       = s_q;
            assign cout      = c_q;
            assign ovf       = ovf_q;
        end
    end

endmodule

// File: tb/tb_rca_pipe.sv
// Self-checking bench for rca_pipe: directed and random beats scored against an
// arithmetic reference model; a second 8-bit instance covers the single-stage case.
module tb_rca_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [31:0] a, b, sum;

    logic        in_valid8, in_ready8, cin8, sub8, out_valid8, out_ready8, cout8, ovf8;
    logic [7:0]  a8, b8, sum8;

    int          n_vec = 0;
    int          n_err = 0;
    int          xfer_cnt = 0;
    int          acc_cnt = 0;
    logic [33:0] exp_q[$];

    always #5 clk = ~clk;

    rca_pipe #(.WIDTH(32), .SEG_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    rca_pipe #(.WIDTH(8), .SEG_W(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(cin8), .sub(sub8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .sum(sum8), .cout(cout8), .ovf(ovf8)
    );

    // Result as {ovf, cout, sum} from plain unsigned/signed arithmetic on w-bit operands.
    function automatic logic [33:0] ref_op(int w, longint unsigned x, longint unsigned y,
                                           bit ci, bit sb);
        longint unsigned m;
        longint unsigned full;
        longint          sx, sy, sr, lim;
        logic [33:0]     r;
        m   = (64'd1 << w) - 64'd1;
        lim = longint'(64'd1 << (w - 1));
        sx  = (x >= (64'd1 << (w - 1))) ? longint'(x) - longint'(64'd1 << w) : longint'(x);
        sy  = (y >= (64'd1 << (w - 1))) ? longint'(y) - longint'(64'd1 << w) : longint'(y);
        r   = '0;
        if (sb) begin
            full  = (x - y) & m;
            r[32] = (x >= y);
            sr    = sx - sy;
        end else begin
            full  = x + y + 64'(ci);
            r[32] = ((full >> w) != 64'd0);
            full  = full & m;
            sr    = sx + sy + 64'(ci);
        end
        r[31:0] = full[31:0];
        r[33]   = (sr >= lim) || (sr < -lim);
        return r;
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock: score outputs at negedge, then record the acceptance after the edge.
    task automatic tick();
        logic        acc, xf, r;
        logic [33:0] e;
        @(negedge clk);
        acc = in_valid && in_ready;
        xf  = out_valid && out_ready;
        r   = rst;
        if (xf && !r) begin
            check("no_dup", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sum", 64'(sum), 64'(e[31:0]));
                check("cout", 64'(cout), 64'(e[32]));
                check("ovf", 64'(ovf), 64'(e[33]));
                xfer_cnt++;
            end
        end
        @(posedge clk);
        #1;
        if (r) begin
            exp_q.delete();
        end else if (acc) begin
            exp_q.push_back(ref_op(32, 64'(a), 64'(b), cin, sub));
            acc_cnt++;
        end
    endtask

    task automatic send_one(logic [31:0] x, logic [31:0] y, logic ci, logic sb);
        a = x; b = y; cin = ci; sub = sb;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            check("latency", 64'(out_valid), 64'(k == 4));
            tick();
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && t < 50) begin
            tick();
            t++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic rand_beat();
        a   = $urandom;
        b   = $urandom;
        cin = 1'($urandom_range(0, 1));
        sub = 1'($urandom_range(0, 1));
    endtask

    initial begin
        logic [31:0] v8a[9];
        logic [31:0] v8b[9];
        logic [1:0]  v8f[9];
        logic [33:0] e;
        int          t;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        in_valid8 = 1'b0; out_ready8 = 1'b1; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_cout", 64'(cout), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);

        send_one(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        send_one(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        send_one(32'h0000_0005, 32'h0000_0003, 1'b1, 1'b0);
        send_one(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1);
        send_one(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);

        // Back-to-back stream: outputs start 4 cycles after first acceptance, no gaps.
        xfer_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            a = 32'(i); b = 32'(i) * 32'h0101_0101;
            sub = 1'(i % 2); cin = 1'((i / 2) % 2);
            in_valid = 1'b1;
            check("stream_in_ready", 64'(in_ready), 64'd1);
            tick();
        end
        check("stream_xfers_mid", 64'(xfer_cnt), 64'd12);
        in_valid = 1'b0;
        repeat (4) tick();
        check("stream_xfers_all", 64'(xfer_cnt), 64'd16);
        check("stream_q_empty", 64'(exp_q.size()), 64'd0);

        // Backpressure on a full pipe.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rand_beat();
            in_valid = 1'b1;
            tick();
        end
        rand_beat();
        for (int i = 0; i < 5; i++) begin
            e = exp_q[0];
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_sum", 64'(sum), 64'(e[31:0]));
            check("bp_cout", 64'(cout), 64'(e[32]));
            check("bp_ovf", 64'(ovf), 64'(e[33]));
            tick();
        end
        out_ready = 1'b1;
        xfer_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            rand_beat();
        end
        check("bp_resume_xfers", 64'(xfer_cnt), 64'd8);
        drain();

        // Random valid/ready traffic.
        acc_cnt = 0;
        xfer_cnt = 0;
        t = 0;
        while (acc_cnt < 200 && t < 5000) begin
            rand_beat();
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            tick();
            t++;
        end
        check("rand_accepted", 64'(acc_cnt), 64'd200);
        drain();
        check("rand_delivered", 64'(xfer_cnt), 64'd200);

        // Reset in the middle of a stream discards all in-flight beats.
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = 32'(i + 10); b = 32'(i + 20); cin = 1'b0; sub = 1'b0;
            in_valid = 1'b1;
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 6; i++) begin
            check("mid_rst_out_valid", 64'(out_valid), 64'd0);
            check("mid_rst_sum", 64'(sum), 64'd0);
            check("mid_rst_cout", 64'(cout), 64'd0);
            check("mid_rst_ovf", 64'(ovf), 64'd0);
            tick();
        end
        send_one(32'd2, 32'd3, 1'b0, 1'b0);

        // Single-stage instance: latency of one.
        v8a[0] = 32'hFF; v8b[0] = 32'h01; v8f[0] = 2'b00;
        v8a[1] = 32'h7F; v8b[1] = 32'h01; v8f[1] = 2'b00;
        v8a[2] = 32'h05; v8b[2] = 32'h03; v8f[2] = 2'b01;
        v8a[3] = 32'h05; v8b[3] = 32'h07; v8f[3] = 2'b10;
        v8a[4] = 32'h80; v8b[4] = 32'h01; v8f[4] = 2'b10;
        for (int i = 5; i < 9; i++) begin
            v8a[i] = 32'($urandom_range(0, 255));
            v8b[i] = 32'($urandom_range(0, 255));
            v8f[i] = 2'($urandom_range(0, 3));
        end
        for (int i = 0; i < 9; i++) begin
            a8 = v8a[i][7:0]; b8 = v8b[i][7:0]; sub8 = v8f[i][1]; cin8 = v8f[i][0];
            in_valid8 = 1'b1;
            check("w8_in_ready", 64'(in_ready8), 64'd1);
            tick();
            in_valid8 = 1'b0;
            e = ref_op(8, 64'(v8a[i]), 64'(v8b[i]), v8f[i][0], v8f[i][1]);
            check("w8_out_valid", 64'(out_valid8), 64'd1);
            check("w8_sum", 64'(sum8), 64'(e[7:0]));
            check("w8_cout", 64'(cout8), 64'(e[32]));
            check("w8_ovf", 64'(ovf8), 64'(e[33]));
            tick();
            check("w8_bubble", 64'(out_valid8), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
